// File: rtl/nmi_tmo_guard_pkg.sv
// Shared types and constants for the NMI timeout guard.
// Holds the guard FSM encoding, the default abort read data and the fault-count helper.
package nmi_tmo_guard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_ABORT = 2'd3
  } state_e;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;
  localparam logic [7:0]  FAULT_CNT_MAX = 8'hFF;

  // Saturating increment for the abort counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == FAULT_CNT_MAX) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nmi_tmo_cnt.sv
// Downstream wait counter: clears outside a request, counts stalled cycles,
// flags the last permitted cycle.
module nmi_tmo_cnt
  import nmi_tmo_guard_pkg::*;
#(
  parameter int TMO_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TMO_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TMO_CYCLES - 1);

  logic [CW-1:0] cnt_r;

  // Stall counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_r <= '0;
    end else if (clr_i) begin
      cnt_r <= '0;
    end else if (en_i) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired_o = (cnt_r == LAST);

endmodule

// File: rtl/nmi_tmo_guard.sv
// NMI request guard: forwards one upstream access to the APB-wrapper port and
// aborts it with error data if the downstream does not answer in time.
module nmi_tmo_guard
  import nmi_tmo_guard_pkg::*;
#(
  parameter int          TMO_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA  = ERR_RDATA_DEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        s_valid_i,
  input  logic [31:0] s_addr_i,
  input  logic [31:0] s_wdata_i,
  input  logic [3:0]  s_wstrb_i,
  output logic        s_ready_o,
  output logic [31:0] s_rdata_o,
  output logic        m_valid_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  output logic [3:0]  m_wstrb_o,
  input  logic        m_ready_i,
  input  logic [31:0] m_rdata_i,
  input  logic        fault_clr_i,
  output logic        tmo_irq_o,
  output logic [31:0] fault_addr_o,
  output logic [7:0]  fault_cnt_o
);

  state_e state_r;
  logic   expired_s;
  logic   cnt_clr_s;
  logic   cnt_en_s;

  // Counter control: run only while a request is outstanding and unanswered.
  always_comb begin
    cnt_clr_s = 1'b1;
    cnt_en_s  = 1'b0;
    if (state_r == ST_REQ) begin
      cnt_clr_s = 1'b0;
      cnt_en_s  = ~m_ready_i;
    end else begin
      cnt_clr_s = 1'b1;
      cnt_en_s  = 1'b0;
    end
  end

  nmi_tmo_cnt #(
    .TMO_CYCLES (TMO_CYCLES)
  ) u_cnt (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (cnt_clr_s),
    .en_i      (cnt_en_s),
    .expired_o (expired_s)
  );

  // Guard FSM with registered upstream, downstream and fault outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r      <= ST_IDLE;
      s_ready_o    <= 1'b0;
      s_rdata_o    <= 32'h0000_0000;
      m_valid_o    <= 1'b0;
      m_addr_o     <= 32'h0000_0000;
      m_wdata_o    <= 32'h0000_0000;
      m_wstrb_o    <= 4'h0;
      tmo_irq_o    <= 1'b0;
      fault_addr_o <= 32'h0000_0000;
      fault_cnt_o  <= 8'd0;
    end else begin
      // A clear is overridden below when it lands on the abort edge.
      if (fault_clr_i) begin
        fault_cnt_o  <= 8'd0;
        fault_addr_o <= 32'h0000_0000;
      end
      case (state_r)
        ST_IDLE: begin
          s_ready_o <= 1'b0;
          s_rdata_o <= 32'h0000_0000;
          tmo_irq_o <= 1'b0;
          if (s_valid_i) begin
            m_valid_o <= 1'b1;
            m_addr_o  <= s_addr_i;
            m_wdata_o <= s_wdata_i;
            m_wstrb_o <= s_wstrb_i;
            state_r   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (m_ready_i) begin
            m_valid_o <= 1'b0;
            s_ready_o <= 1'b1;
            s_rdata_o <= m_rdata_i;
            state_r   <= ST_RESP;
          end else if (expired_s) begin
            m_valid_o    <= 1'b0;
            s_ready_o    <= 1'b1;
            s_rdata_o    <= ERR_RDATA;
            tmo_irq_o    <= 1'b1;
            fault_addr_o <= m_addr_o;
            fault_cnt_o  <= fault_clr_i ? 8'd1 : sat_inc8(fault_cnt_o);
            state_r      <= ST_ABORT;
          end
        end
        ST_RESP, ST_ABORT: begin
          s_ready_o <= 1'b0;
          s_rdata_o <= 32'h0000_0000;
          tmo_irq_o <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          m_valid_o <= 1'b0;
          s_ready_o <= 1'b0;
          s_rdata_o <= 32'h0000_0000;
          tmo_irq_o <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
